uart_rx_ram_wr: RTL
===================

// Module: uart_rx_ram_wr
// PURPOSE
//  RS232 receive path feeding the 256x8 RAM: deserialises 8N1 frames on rs232_rx and
//  writes each good byte to sequential RAM addresses from 0. Counterpart of the TX path
//  that reads RAM and transmits. Sits between the board RX pin and the RAM write port.
// PARAMETERS
//  CLK_FREQ  50_000_000  system clock, Hz
//  BAUD      9600        line rate, bit/s; BIT_CNT = CLK_FREQ/BAUD (5208 at defaults)
//  ADDR_W    8           RAM address width (depth 2**ADDR_W)
//  DATA_W    8           data bits per frame, also RAM data width
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  rs232_rx    in   1       asynchronous serial input, idle high
//  ram_we      out  1       RAM write strobe, one-cycle pulse
//  ram_waddr   out  ADDR_W  RAM write address
//  ram_wdata   out  DATA_W  RAM write data, valid while ram_we=1
//  rx_done     out  1       one-cycle pulse per accepted byte (same cycle as ram_we)
//  frame_err   out  1       one-cycle pulse: stop bit sampled low, byte dropped
//  parity_err  out  1       one-cycle pulse: parity mismatch, byte dropped (0 w/o macro)
//  wr_full     out  1       level: 2**ADDR_W bytes written, further bytes dropped
//  state_led   out  1       level: high while FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, ram_waddr=0, FSM=IDLE, byte count 0, sync FFs to 1.
//  rs232_rx through 2-FF synchroniser; falling edge of synced line starts a frame.
//  FSM IDLE->START->DATA->(PARITY)->STOP->WRITE->IDLE.
//  START: wait BIT_CNT/2, resample; line high => glitch, back to IDLE, no pulses.
//  DATA: sample every BIT_CNT at bit centre, LSB first, DATA_W bits into shift reg.
//  STOP: sample at centre; 0 => frame_err pulse, IDLE, no write. 1 => WRITE.
//  WRITE (1 cycle): if !wr_full: ram_we=rx_done=1, ram_wdata=byte, ram_waddr=addr;
//   addr increments the following cycle. If wr_full: no strobe, byte discarded.
//  Latency: ram_we is 1 clk after the stop-bit centre sample.
//  Wrap: after write at addr 2**ADDR_W-1, addr returns to 0 and wr_full sets; it
//   stays set until rst (no overwrite of earlier data).
//  FSM returns to IDLE mid-stop-bit; a start edge arriving then is detected normally.
//  Line held low (break): frame_err once, then IDLE waits for line high before
//   re-arming edge detect; no repeated frames.
//  rst mid-frame: partial byte discarded, no strobe, state as reset.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one extra bit;
//   even-parity mismatch => parity_err pulse, IDLE after stop bit, no write;
//   frame_err takes priority if both fail.
//  Undefined: 8N1, no PARITY state, parity_err tied 0.
// STRUCTURE
//  Shared header uart_defs.vh: FSM state localparams, BIT_CNT/HALF_CNT calc,
//   counter widths via clog2 function; shared with TX path.
//  Sub-module uart_rx_bit_timer: baud counter with start(half)/restart inputs and
//   a one-cycle sample_tick output. FSM, shift reg, addr counter in top.
// TESTING (9600 baud, 50 MHz, 104.16 us/bit)
//  Reset then send 0x55 -> one ram_we, addr 0, wdata 0x55, rx_done same cycle.
//  Send 0xA3,0x00,0xFF back-to-back -> writes at addr 0,1,2, data in order.
//  400 ns low glitch on idle line -> no ram_we, no frame_err, FSM back IDLE.
//  Frame 0x3C with stop bit low -> frame_err pulse, no ram_we, next 0x3C at addr 0.
//  Send 257 bytes -> 256 writes addr 0..255, wr_full after 256th, 257th dropped.
//  Assert rst during data bit 4 -> no write; next byte 0x81 lands at addr 0.
//  PARITY_EN: 0x07 with odd parity bit -> parity_err, no write; correct -> write.

Source files
------------

// File: rtl/uart_rx_ram_wr_pkg.sv
// Shared definitions for the RS232 receive-to-RAM path: FSM encoding and counter sizing.
package uart_rx_ram_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WRITE
  } rx_state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_ram_wr_bit_timer.sv
// Baud-rate sample timer: `start` arms a half-bit delay, then while `run` is high
// it emits a one-cycle sample_tick every BIT_CNT clocks (bit centres).
module uart_rx_ram_wr_bit_timer
  import uart_rx_ram_wr_pkg::*;
#(
  parameter int BIT_CNT  = 5208,
  parameter int HALF_CNT = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic sample_tick
);

  localparam int CNT_W = cnt_width(BIT_CNT);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(HALF_CNT - 1);
    end else if (run) begin
      if (cnt == '0) cnt <= CNT_W'(BIT_CNT - 1);
      else           cnt <= cnt - 1'b1;
    end
  end

  assign sample_tick = run && !start && (cnt == '0);

endmodule

// File: rtl/uart_rx_ram_wr.sv
// RS232 8N1 receiver writing each good byte to sequential RAM addresses from 0.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_ram_wr
  import uart_rx_ram_wr_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rs232_rx,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              rx_done,
  output logic              frame_err,
  output logic              parity_err,
  output logic              wr_full,
  output logic              state_led
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int IDX_W    = cnt_width(DATA_W);

  rx_state_e         state, state_nxt;
  logic              rx_s1, rx_s2, rx_prev;
  logic              start_edge, tick, timer_run, bit_last, par_bad;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;
  logic [ADDR_W-1:0] addr;

  // Only a high-to-low transition starts a frame, so a held-low line (break)
  // cannot re-trigger until it has returned high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rs232_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign start_edge = rx_prev & ~rx_s2;
  assign timer_run  = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
  assign bit_last   = (bit_idx == IDX_W'(DATA_W - 1));

  uart_rx_ram_wr_bit_timer #(
    .BIT_CNT  (BIT_CNT),
    .HALF_CNT (HALF_CNT)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .start       ((state == ST_IDLE) && start_edge),
    .run         (timer_run),
    .sample_tick (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst)                              par_bit <= 1'b0;
    else if ((state == ST_PARITY) && tick) par_bit <= rx_s2;
  end

  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the comb block infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_edge) state_nxt = ST_START;
      ST_START: if (tick) state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (tick && bit_last) state_nxt = ST_PARITY;
      ST_PARITY: if (tick) state_nxt = ST_STOP;
`else
      ST_DATA:   if (tick && bit_last) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (tick) state_nxt = (!rx_s2 || par_bad) ? ST_IDLE : ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Error pulses fire on the stop-bit sample; frame_err wins over parity_err.
  always_comb begin
    ram_we     = 1'b0;
    rx_done    = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    state_led  = (state != ST_IDLE);
    if ((state == ST_STOP) && tick) begin
      if (!rx_s2)       frame_err  = 1'b1;
      else if (par_bad) parity_err = 1'b1;
    end
    if ((state == ST_WRITE) && !wr_full) begin
      ram_we  = 1'b1;
      rx_done = 1'b1;
    end
  end

  // Address wraps to 0 after the last location; wr_full then locks out writes until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      shift   <= '0;
      addr    <= '0;
      wr_full <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && tick) begin
        shift   <= {rx_s2, shift[DATA_W-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (ram_we) begin
        addr <= addr + 1'b1;
        if (addr == '1) wr_full <= 1'b1;
      end
    end
  end

  assign ram_waddr = addr;
  assign ram_wdata = shift;

endmodule
